vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter DIV, default 4: system clocks per pixel when the divider is compiled in; legal range 2..16.
REQ-002 SHALL have port clk, input, 1: system clock, the single clock of the block.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port pix_tick, output, 1: pixel clock-enable for the downstream region and display logic.
REQ-005 SHALL have port hcount, output, 10: current pixel column, range 0..799.
REQ-006 SHALL have port vcount, output, 10: current line, range 0..524.
REQ-007 SHALL have port hsync, output, 1: horizontal sync, active low.
REQ-008 SHALL have port vsync, output, 1: vertical sync, active low.
REQ-009 SHALL have port video_on, output, 1: high while (hcount, vcount) is inside 640x480.
REQ-010 SHALL have port frame_start, output, 1: one-clk pulse at the start of each frame.

Function
REQ-011 SHALL advance hcount and vcount only on clk edges where pix_tick is 1; all other edges hold every counter.
REQ-012 SHALL increment hcount by 1 per pix_tick and wrap it from 799 to 0.
REQ-013 SHALL increment vcount only on the tick where hcount wraps, and wrap vcount from 524 to 0 on the tick where hcount wraps 799->0 and vcount is 524.
REQ-014 SHALL register all outputs, and SHALL derive hsync, vsync and video_on from the next-state counter values so they always match the hcount/vcount presented in the same cycle (zero skew).
REQ-015 SHALL drive hsync = 0 iff hcount is in 656..751 inclusive, else 1.
REQ-016 SHALL drive vsync = 0 iff vcount is in 490..491 inclusive, else 1.
REQ-017 SHALL drive video_on = 1 iff hcount <= 639 and vcount <= 479.
REQ-018 SHALL assert frame_start for exactly one clk, the cycle in which (hcount, vcount) first reads (0,0) after wrapping from (799,524); it SHALL NOT assert on exit from reset.
REQ-019 SHALL never present out-of-range counter values (hcount > 799 or vcount > 524), including on the simultaneous h-wrap and v-wrap edge.

Reset
REQ-020 SHALL, while rst_n = 0, force hcount = 0, vcount = 0, hsync = 1, vsync = 1, video_on = 1, frame_start = 0, pix_tick = 0, and clear the divider count to 0, asynchronously.
REQ-021 SHALL, on reset release, start counting from (0,0), with the first pix_tick DIV clks after release (divider in) or 1 clk after release (divider out).
REQ-022 SHALL, when reset is asserted mid-line or mid-frame, abandon the frame immediately with no partial frame_start pulse.

Configuration
REQ-023 SHALL use macro VGA_TIMING_CLKDIV_EN.
REQ-024 SHALL, with VGA_TIMING_CLKDIV_EN defined, generate pix_tick high for one clk when the divider count = DIV-1, wrapping the count to 0 (tick period DIV clks; 100 MHz -> 25 MHz at DIV=4).
REQ-025 SHALL, without VGA_TIMING_CLKDIV_EN, hold pix_tick = 1 out of reset, ignore DIV, and advance counters every clk (clk is the pixel clock).

Structure
REQ-026 SHALL take timing constants from shared package vga_pkg: H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, and the 10-bit coordinate width; no literal timing numbers in the module.
REQ-027 SHALL implement the divider as sub-module pix_tick_div, instantiated only under VGA_TIMING_CLKDIV_EN.

Verification
REQ-028 SHALL cover: divider in, DIV=4, release reset -> pix_tick high at clks 4, 8, 12, ...; hcount = 1 after the first tick.
REQ-029 SHALL cover: run one line -> hsync low for exactly 96 ticks starting at hcount = 656; video_on falls at the hcount 639->640 transition.
REQ-030 SHALL cover: run a full frame -> 420000 ticks between frame_start pulses; vsync low for exactly 2 lines (1600 ticks) starting at vcount = 490.
REQ-031 SHALL cover: wrap edge at (799,524) -> next tick gives (0,0) and frame_start = 1 for one clk only (not DIV clks).
REQ-032 SHALL cover: assert rst_n = 0 at (300,200) between clk edges -> outputs reach reset values immediately; after release, counting restarts at (0,0) and no frame_start occurs.
REQ-033 SHALL cover: divider out -> pix_tick = 1 constantly and a full frame takes 420000 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and coordinate type shared by the VGA timing block.
package vga_pkg;
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;
    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    function automatic logic in_span(coord_t x, coord_t lo, coord_t len);
        return x >= lo && x < lo + len;
    endfunction
endpackage

// File: rtl/pix_tick_div.sv
// pix_tick_div: divides clk by DIV; the count reaching DIV-1 raises tick for the following clk.
module pix_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_d, cnt_q;
    logic          tick_d, tick_q;

    always_comb begin
        tick_d = cnt_q == CW'(DIV - 1);
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 counters, syncs and frame pulse, all registered with zero skew.
// Define VGA_TIMING_CLKDIV_EN to derive the pixel tick via pix_tick_div; otherwise clk is the pixel clock.
module vga_timing
    import vga_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   pix_tick,
    output coord_t hcount,
    output coord_t vcount,
    output logic   hsync,
    output logic   vsync,
    output logic   video_on,
    output logic   frame_start
);
    logic   tick, h_last, v_last;
    coord_t hcount_d, hcount_q, vcount_d, vcount_q;
    logic   hsync_d, hsync_q, vsync_d, vsync_q;
    logic   video_on_d, video_on_q, frame_start_d, frame_start_q;

`ifdef VGA_TIMING_CLKDIV_EN
    pix_tick_div #(.DIV(DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );
`else
    logic tick_q;
    logic unused_div;
    assign unused_div = DIV != 0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= 1'b1;
    end
    assign tick = tick_q;
`endif

    // Sync/video flags are computed from the next counter values so they land in the same cycle.
    always_comb begin
        h_last        = hcount_q == H_TOTAL - 1'b1;
        v_last        = vcount_q == V_TOTAL - 1'b1;
        hcount_d      = tick ? (h_last ? '0 : hcount_q + 1'b1) : hcount_q;
        vcount_d      = (tick && h_last) ? (v_last ? '0 : vcount_q + 1'b1) : vcount_q;
        hsync_d       = !in_span(hcount_d, H_VISIBLE + H_FP, H_SYNC);
        vsync_d       = !in_span(vcount_d, V_VISIBLE + V_FP, V_SYNC);
        video_on_d    = hcount_d < H_VISIBLE && vcount_d < V_VISIBLE;
        frame_start_d = tick && h_last && v_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = tick;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks vga_timing every clk against an arithmetic model (clks since reset release),
// plus a table of frame positions and hand sequences for line, frame, wrap and mid-frame reset.
module tb_vga_timing;
    localparam int DIV = 4;
`ifdef VGA_TIMING_CLKDIV_EN
    localparam int P = DIV;
`else
    localparam int P = 1;
`endif
    localparam int FRAME = 800 * 525;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       pix_tick, hsync, vsync, video_on, frame_start;
    logic [9:0] hcount, vcount;

    vga_timing #(.DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int adv;
        int h;
        int v;
        bit hs;
        bit vs;
        bit von;
    } vec_t;
    vec_t tbl [15];

    int     checks = 0, errors = 0;
    longint n = 0;
    int     tp = 0;
    bit     tbl_on = 0;
    int     pix_cnt, hs_low, hs_start, vs_low, vs_start, von_fall, von_prev, fs_pix;
    logic [9:0] prev_h = '0, prev_v = '0;
    logic       prev_von = 1'b1;

    function automatic int adv_of(longint k);
        return k == 0 ? 0 : int'((k - 1) / P);
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (clk %0d after release)", name, act, exp, n);
        end
    endtask

    task automatic check_model();
        int a = adv_of(n);
        int h = a % 800;
        int v = (a / 800) % 525;
        logic [24:0] exp_v, act_v;
        exp_v = {n > 0 && n % P == 0, 10'(h), 10'(v), !(h >= 656 && h <= 751), !(v >= 490 && v <= 491),
                 h < 640 && v < 480, a > 0 && a % FRAME == 0 && (n - 1) % P == 0};
        act_v = {pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model clk %0d: got tick=%b h=%0d v=%0d hs=%b vs=%b von=%b fs=%b expected %b %0d %0d %b %b %b %b",
                     n, act_v[24], act_v[23:14], act_v[13:4], act_v[3], act_v[2], act_v[1], act_v[0],
                     exp_v[24], exp_v[23:14], exp_v[13:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic clear_stats();
        pix_cnt = 0; hs_low = 0; hs_start = -1; vs_low = 0; vs_start = -1;
        von_fall = -1; von_prev = -1; fs_pix = -1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
        check_model();
        if (rst_n) begin
            if ({hcount, vcount} != {prev_h, prev_v}) begin
                pix_cnt++;
                if (vcount == 0 && !hsync) begin
                    if (hs_start < 0) hs_start = int'(hcount);
                    hs_low++;
                end
                if (!vsync) begin
                    if (vs_start < 0) vs_start = int'(vcount);
                    vs_low++;
                end
            end
            if (prev_von && !video_on && vcount == 0 && von_fall < 0) begin
                von_fall = int'(hcount);
                von_prev = int'(prev_h);
            end
            if (frame_start && fs_pix < 0) fs_pix = pix_cnt;
            if (tbl_on && tp < 15 && adv_of(n) == tbl[tp].adv) begin
                check($sformatf("tbl[%0d] h,v,hs,vs,von", tp), {hcount, vcount, hsync, vsync, video_on},
                      {10'(tbl[tp].h), 10'(tbl[tp].v), tbl[tp].hs, tbl[tp].vs, tbl[tp].von});
                tp++;
            end
        end
        prev_h = hcount; prev_v = vcount; prev_von = video_on;
    endtask

    task automatic async_reset(int dly);
        #(dly) rst_n = 1'b0;
        n = 0;
        #1;
        check("async_reset_outputs", {pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start},
              {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    endtask

    initial begin
        int k;
        tbl[0]  = '{0,      0,   0,   1, 1, 1};
        tbl[1]  = '{639,    639, 0,   1, 1, 1};
        tbl[2]  = '{640,    640, 0,   1, 1, 0};
        tbl[3]  = '{655,    655, 0,   1, 1, 0};
        tbl[4]  = '{656,    656, 0,   0, 1, 0};
        tbl[5]  = '{751,    751, 0,   0, 1, 0};
        tbl[6]  = '{752,    752, 0,   1, 1, 0};
        tbl[7]  = '{799,    799, 0,   1, 1, 0};
        tbl[8]  = '{800,    0,   1,   1, 1, 1};
        tbl[9]  = '{383839, 639, 479, 1, 1, 1};
        tbl[10] = '{384000, 0,   480, 1, 1, 0};
        tbl[11] = '{392000, 0,   490, 1, 0, 0};
        tbl[12] = '{393599, 799, 491, 1, 0, 0};
        tbl[13] = '{393600, 0,   492, 1, 1, 0};
        tbl[14] = '{419999, 799, 524, 1, 1, 0};
        clear_stats();

        repeat (3) step();
        check("reset_outputs", {pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start},
              {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});

        // First tick latency, first advance, tick period.
        rst_n = 1'b1;
        k = 0;
        do begin step(); k++; end while (!pix_tick && k < 100);
        check("first_tick_clk", k, P);
        step();
        check("hcount_after_first_tick", hcount, 1);
        k = 1;
        while (!pix_tick && k < 100) begin step(); k++; end
        check("tick_period", k, P);

        // Run into line 200, then abandon the frame with a reset between clk edges at (300,200).
        for (int i = 0; i < 170000 * P && !(hcount == 300 && vcount == 200); i++) step();
        check("reached_300_200", {hcount, vcount}, {10'd300, 10'd200});
        check("hsync_low_ticks", hs_low, 96);
        check("hsync_low_start_h", hs_start, 656);
        check("video_on_fall_h", von_fall, 640);
        check("video_on_fall_prev_h", von_prev, 639);
        async_reset(1);
        repeat (2) step();
        check("no_fs_in_reset", frame_start, 0);

        // Restart from (0,0) and run one full frame to the wrap.
        rst_n = 1'b1;
        clear_stats();
        tbl_on = 1;
        for (int i = 0; i < FRAME * P + 8 * P && fs_pix < 0; i++) step();
        tbl_on = 0;
        check("ticks_to_frame_start", fs_pix, FRAME);
        check("wrap_pos", {hcount, vcount}, 20'd0);
        check("fs_at_wrap", frame_start, 1);
        check("table_entries_hit", tp, 15);
        check("vsync_low_ticks", vs_low, 1600);
        check("vsync_low_start_v", vs_start, 490);
        step();
        check("fs_one_clk", frame_start, 0);

        // Random run lengths and reset instants; the model follows every clk.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(20, 3000)) step();
            async_reset(int'($urandom_range(1, 3)));
            repeat ($urandom_range(1, 3)) step();
            rst_n = 1'b1;
        end
        repeat (50) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
